// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the true dual-port RAM.
// The optional output register stage is enabled with TDP_RAM_OUT_REG_EN.
package tdp_ram_pkg;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    localparam int unsigned WIN_WIDTH = 33;

    // Window test done one bit wider so base+depth cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] depth);
        logic [WIN_WIDTH-1:0] a;
        logic [WIN_WIDTH-1:0] lo;
        logic [WIN_WIDTH-1:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, depth};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/tdp_ram_port.sv
// One RAM port: window decode, write-first lane merge and the read response pipeline.
// TDP_RAM_OUT_REG_EN adds a second response stage (latency 2).
module tdp_ram_port
    import tdp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RAM_DEPTH  = 256,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned IDX_WIDTH  = 8,
    parameter rdw_mode_e   RDW_MODE   = RDW_READ_FIRST
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             en,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH-1:0]            rd_word,
    output logic [IDX_WIDTH-1:0]             idx_c,
    output logic                             wr_c,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rvalid,
    output logic                             err
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  win_c;
    logic [DATA_WIDTH-1:0] merged_c;
    logic [DATA_WIDTH-1:0] s1_rdata;
    logic                  s1_rvalid;
    logic                  s1_err;
    logic [DATA_WIDTH-1:0] s1_rdata_nx;
    logic                  s1_rvalid_nx;
    logic                  s1_err_nx;

    assign win_c = in_window(32'(addr), 32'(BASE_ADDR), 32'(RAM_DEPTH));
    assign idx_c = IDX_WIDTH'(32'(addr) - 32'(BASE_ADDR));
    assign wr_c  = en & wr_en & win_c;

    // Post-write view of the addressed word as seen by this port alone
    always_comb begin
        merged_c = rd_word;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) begin
                merged_c[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        s1_rvalid_nx = 1'b0;
        s1_err_nx    = 1'b0;
        s1_rdata_nx  = s1_rdata;
        if (en) begin
            if (!win_c) begin
                s1_rvalid_nx = 1'b1;
                s1_err_nx    = 1'b1;
                s1_rdata_nx  = '0;
            end else if (!wr_en) begin
                s1_rvalid_nx = 1'b1;
                s1_rdata_nx  = rd_word;
            end else if (RDW_MODE == RDW_WRITE_FIRST) begin
                s1_rvalid_nx = 1'b1;
                s1_rdata_nx  = merged_c;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_rdata  <= '0;
            s1_rvalid <= 1'b0;
            s1_err    <= 1'b0;
        end else begin
            s1_rdata  <= s1_rdata_nx;
            s1_rvalid <= s1_rvalid_nx;
            s1_err    <= s1_err_nx;
        end
    end

`ifdef TDP_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] s2_rdata;
    logic                  s2_rvalid;
    logic                  s2_err;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_rdata  <= '0;
            s2_rvalid <= 1'b0;
            s2_err    <= 1'b0;
        end else begin
            s2_rdata  <= s1_rdata;
            s2_rvalid <= s1_rvalid;
            s2_err    <= s1_err;
        end
    end

    assign rdata  = s2_rdata;
    assign rvalid = s2_rvalid;
    assign err    = s2_err;
`else
    assign rdata  = s1_rdata;
    assign rvalid = s1_rvalid;
    assign err    = s1_err;
`endif

endmodule

// File: rtl/tdp_ram.sv
// True dual-port RAM with byte enables, address window and registered reads.
// Define TDP_RAM_OUT_REG_EN for a second output register stage on both ports.
module tdp_ram
    import tdp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 256,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned RDW_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             a_en,
    input  logic                             a_wr_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]            a_addr,
    input  logic [DATA_WIDTH-1:0]            a_wdata,
    output logic [DATA_WIDTH-1:0]            a_rdata,
    output logic                             a_rvalid,
    output logic                             a_err,
    input  logic                             b_en,
    input  logic                             b_wr_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]            b_addr,
    input  logic [DATA_WIDTH-1:0]            b_wdata,
    output logic [DATA_WIDTH-1:0]            b_rdata,
    output logic                             b_rvalid,
    output logic                             b_err
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IDX_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam rdw_mode_e   MODE      = (RDW_MODE == 1) ? RDW_WRITE_FIRST : RDW_READ_FIRST;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [IDX_WIDTH-1:0]  a_idx_c;
    logic [IDX_WIDTH-1:0]  b_idx_c;
    logic                  a_wr_c;
    logic                  b_wr_c;
    logic [DATA_WIDTH-1:0] a_rd_word_c;
    logic [DATA_WIDTH-1:0] b_rd_word_c;
    logic [NUM_BYTES-1:0]  a_lane_we_c;
    logic [NUM_BYTES-1:0]  b_lane_we_c;

    // Pre-edge array contents: both ports see old data on a same-cycle write
    assign a_rd_word_c = mem[a_idx_c];
    assign b_rd_word_c = mem[b_idx_c];

    // Port A owns any lane both ports write at the same address
    always_comb begin
        a_lane_we_c = a_wr_c ? a_be : '0;
        b_lane_we_c = b_wr_c ? b_be : '0;
        if (a_wr_c && b_wr_c && (a_idx_c == b_idx_c)) begin
            b_lane_we_c = b_lane_we_c & ~a_be;
        end
    end

    // Array contents survive reset; only writes are suppressed while it is asserted
    always_ff @(posedge clk or negedge n_rst) begin
        if (n_rst) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (b_lane_we_c[i]) begin
                    mem[b_idx_c][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (a_lane_we_c[i]) begin
                    mem[a_idx_c][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    tdp_ram_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_WIDTH  (IDX_WIDTH),
        .RDW_MODE   (MODE)
    ) u_port_a (
        .clk     (clk),
        .n_rst   (n_rst),
        .en      (a_en),
        .wr_en   (a_wr_en),
        .be      (a_be),
        .addr    (a_addr),
        .wdata   (a_wdata),
        .rd_word (a_rd_word_c),
        .idx_c   (a_idx_c),
        .wr_c    (a_wr_c),
        .rdata   (a_rdata),
        .rvalid  (a_rvalid),
        .err     (a_err)
    );

    tdp_ram_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_WIDTH  (IDX_WIDTH),
        .RDW_MODE   (MODE)
    ) u_port_b (
        .clk     (clk),
        .n_rst   (n_rst),
        .en      (b_en),
        .wr_en   (b_wr_en),
        .be      (b_be),
        .addr    (b_addr),
        .wdata   (b_wdata),
        .rd_word (b_rd_word_c),
        .idx_c   (b_idx_c),
        .wr_c    (b_wr_c),
        .rdata   (b_rdata),
        .rvalid  (b_rvalid),
        .err     (b_err)
    );

endmodule

// File: tb/tb_tdp_ram.sv
// Bench for tdp_ram: two instances (read-first and write-first) share one stimulus stream,
// checked against a word-array model plus a table of directed vectors.
module tb_tdp_ram;

`ifdef TDP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic        rv;
        logic        er;
        logic [31:0] d;
    } out_t;

    typedef struct {
        logic        a_en;
        logic        a_wr;
        logic [3:0]  a_be;
        logic [15:0] a_addr;
        logic [31:0] a_wd;
        logic        b_en;
        logic        b_wr;
        logic [3:0]  b_be;
        logic [15:0] b_addr;
        logic [31:0] b_wd;
        out_t        a_exp;
        logic        a_chk_d;
        out_t        b_exp;
        logic        b_chk_d;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        en   [2];
    logic        wr   [2];
    logic [3:0]  be   [2];
    logic [15:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rd   [2][2];
    logic        rv   [2][2];
    logic        er   [2][2];

    logic [31:0] mdl [16];
    out_t        s1  [2][2];
    out_t        s2  [2][2];
    out_t        snap [3][2][2];
    vec_t        vq [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    tdp_ram #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .RAM_DEPTH(16), .ADDR_WIDTH(16),
              .BASE_ADDR(16), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .n_rst(n_rst),
        .a_en(en[0]), .a_wr_en(wr[0]), .a_be(be[0]), .a_addr(addr[0]), .a_wdata(wd[0]),
        .a_rdata(rd[0][0]), .a_rvalid(rv[0][0]), .a_err(er[0][0]),
        .b_en(en[1]), .b_wr_en(wr[1]), .b_be(be[1]), .b_addr(addr[1]), .b_wdata(wd[1]),
        .b_rdata(rd[0][1]), .b_rvalid(rv[0][1]), .b_err(er[0][1]));

    tdp_ram #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .RAM_DEPTH(16), .ADDR_WIDTH(16),
              .BASE_ADDR(16), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .n_rst(n_rst),
        .a_en(en[0]), .a_wr_en(wr[0]), .a_be(be[0]), .a_addr(addr[0]), .a_wdata(wd[0]),
        .a_rdata(rd[1][0]), .a_rvalid(rv[1][0]), .a_err(er[1][0]),
        .b_en(en[1]), .b_wr_en(wr[1]), .b_be(be[1]), .b_addr(addr[1]), .b_wdata(wd[1]),
        .b_rdata(rd[1][1]), .b_rvalid(rv[1][1]), .b_err(er[1][1]));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic bit inwin(input logic [15:0] a);
        return (a >= 16'h10) && (a < 16'h20);
    endfunction

    function automatic logic [31:0] init_w(input int k);
        if (k == 2) return 32'hAABBCCDD;
        if (k == 4) return 32'h0;
        return 32'hC0DE0000 | 32'(k);
    endfunction

    function automatic out_t mk(input logic v, input logic e, input logic [31:0] d);
        out_t o;
        o.rv = v; o.er = e; o.d = d;
        return o;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++) begin
                s1[m][p] = '0;
                s2[m][p] = '0;
            end
    endtask

    // Response seen at one edge follows from the old word; B's write lands before A's so A wins lanes
    task automatic model_edge();
        out_t nx [2][2];
        int   k;
        if (!n_rst) begin
            model_reset();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            k = int'(addr[p]) - 16;
            for (int m = 0; m < 2; m++) begin
                nx[m][p] = mk(1'b0, 1'b0, s1[m][p].d);
                if (en[p]) begin
                    if (!inwin(addr[p]))  nx[m][p] = mk(1'b1, 1'b1, 32'h0);
                    else if (!wr[p])      nx[m][p] = mk(1'b1, 1'b0, mdl[k]);
                    else if (m == 1)      nx[m][p] = mk(1'b1, 1'b0, merge(mdl[k], wd[p], be[p]));
                end
            end
        end
        for (int p = 1; p >= 0; p--) begin
            if (en[p] && wr[p] && inwin(addr[p])) begin
                k = int'(addr[p]) - 16;
                mdl[k] = merge(mdl[k], wd[p], be[p]);
            end
        end
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++) begin
                s2[m][p] = s1[m][p];
                s1[m][p] = nx[m][p];
            end
    endtask

    task automatic cmp(input string nm, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got rv=%0b err=%0b rdata=%h, want rv=%0b err=%0b rdata=%h",
                     nm, act.rv, act.er, act.d, exp.rv, exp.er, exp.d);
        end
    endtask

    function automatic out_t act_of(input int m, input int p);
        return mk(rv[m][p], er[m][p], rd[m][p]);
    endfunction

    task automatic check_all(input string tag);
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++)
                cmp($sformatf("%s rdw%0d port%s", tag, m, (p == 0) ? "A" : "B"),
                    act_of(m, p), (LAT == 2) ? s2[m][p] : s1[m][p]);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic capture(input int t);
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++)
                snap[t][m][p] = act_of(m, p);
    endtask

    task automatic set_port(input int p, input logic e, input logic w, input logic [3:0] b,
                            input logic [15:0] a, input logic [31:0] d);
        en[p] = e; wr[p] = w; be[p] = b; addr[p] = a; wd[p] = d;
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    endtask

    // Apply one cycle of stimulus, then one idle cycle; snap[LAT] holds the response
    task automatic pulse(input string tag);
        tick(tag);
        capture(1);
        idle();
        tick(tag);
        capture(2);
    endtask

    task automatic add_vec(input logic ae, input logic aw, input logic [3:0] ab, input logic [15:0] aa,
                           input logic [31:0] ad, input logic bee, input logic bw, input logic [3:0] bb,
                           input logic [15:0] ba, input logic [31:0] bd,
                           input out_t aex, input logic ac, input out_t bex, input logic bc);
        vec_t v;
        v.a_en = ae; v.a_wr = aw; v.a_be = ab; v.a_addr = aa; v.a_wd = ad;
        v.b_en = bee; v.b_wr = bw; v.b_be = bb; v.b_addr = ba; v.b_wd = bd;
        v.a_exp = aex; v.a_chk_d = ac; v.b_exp = bex; v.b_chk_d = bc;
        vq.push_back(v);
    endtask

    initial begin
        out_t a_act;
        out_t b_act;
        out_t a_exp;
        out_t b_exp;
        logic [15:0] ra;
        logic [31:0] word;

        idle();
        n_rst = 1'b0;
        model_reset();
        tick("reset");
        tick("reset");
        n_rst = 1'b1;

        // Preload every word so later reads have known contents
        for (int k = 0; k < 16; k += 2) begin
            set_port(0, 1'b1, 1'b1, 4'hF, 16'(16 + k), init_w(k));
            set_port(1, 1'b1, 1'b1, 4'hF, 16'(17 + k), init_w(k + 1));
            tick("preload");
        end
        idle();
        tick("preload");

        // Directed vectors; expectations are for the read-first instance
        add_vec(1,1,4'hF,16'h11,32'hDEADBEEF, 0,0,4'h0,16'h00,32'h0,
                mk(0,0,0),0, mk(0,0,0),0);
        add_vec(0,0,4'h0,16'h00,32'h0, 1,0,4'h0,16'h11,32'h0,
                mk(0,0,0),0, mk(1,0,32'hDEADBEEF),1);
        add_vec(1,0,4'h0,16'h12,32'h0, 0,0,4'h0,16'h00,32'h0,
                mk(1,0,32'hAABBCCDD),1, mk(0,0,0),0);
        add_vec(1,1,4'h5,16'h12,32'h11223344, 0,0,4'h0,16'h00,32'h0,
                mk(0,0,0),0, mk(0,0,0),0);
        add_vec(0,0,4'h0,16'h00,32'h0, 1,0,4'h0,16'h12,32'h0,
                mk(0,0,0),0, mk(1,0,32'hAA22CC44),1);
        add_vec(1,1,4'h3,16'h13,32'h01010101, 1,1,4'hF,16'h13,32'h02020202,
                mk(0,0,0),0, mk(0,0,0),0);
        add_vec(1,0,4'h0,16'h13,32'h0, 0,0,4'h0,16'h00,32'h0,
                mk(1,0,32'h02020101),1, mk(0,0,0),0);
        add_vec(1,1,4'hF,16'h14,32'hFFFFFFFF, 1,0,4'h0,16'h14,32'h0,
                mk(0,0,0),0, mk(1,0,32'h0),1);
        add_vec(0,0,4'h0,16'h00,32'h0, 1,0,4'h0,16'h14,32'h0,
                mk(0,0,0),0, mk(1,0,32'hFFFFFFFF),1);
        add_vec(1,0,4'h0,16'h0F,32'h0, 1,1,4'hF,16'h20,32'h55555555,
                mk(1,1,32'h0),1, mk(1,1,32'h0),1);
        add_vec(1,0,4'h0,16'h1F,32'h0, 1,0,4'h0,16'h10,32'h0,
                mk(1,0,init_w(15)),1, mk(1,0,init_w(0)),1);
        add_vec(1,1,4'h0,16'h15,32'hAAAAAAAA, 1,0,4'h0,16'h15,32'h0,
                mk(0,0,0),0, mk(1,0,init_w(5)),1);
        add_vec(1,0,4'h0,16'h15,32'h0, 1,0,4'h0,16'h15,32'h0,
                mk(1,0,init_w(5)),1, mk(1,0,init_w(5)),1);
        add_vec(1,0,4'h0,16'h20,32'h0, 1,0,4'h0,16'h1F,32'h0,
                mk(1,1,32'h0),1, mk(1,0,init_w(15)),1);

        foreach (vq[i]) begin
            set_port(0, vq[i].a_en, vq[i].a_wr, vq[i].a_be, vq[i].a_addr, vq[i].a_wd);
            set_port(1, vq[i].b_en, vq[i].b_wr, vq[i].b_be, vq[i].b_addr, vq[i].b_wd);
            pulse($sformatf("vec%0d", i));
            a_act = snap[LAT][0][0];
            b_act = snap[LAT][0][1];
            a_exp = vq[i].a_exp;
            b_exp = vq[i].b_exp;
            if (!vq[i].a_chk_d) begin a_act.d = '0; a_exp.d = '0; end
            if (!vq[i].b_chk_d) begin b_act.d = '0; b_exp.d = '0; end
            cmp($sformatf("table vec%0d A", i), a_act, a_exp);
            cmp($sformatf("table vec%0d B", i), b_act, b_exp);
        end

        // Window scan: out-of-window accesses above must not have touched the array
        for (int k = 0; k < 16; k++) begin
            word = (k == 1) ? 32'hDEADBEEF : (k == 2) ? 32'hAA22CC44 :
                   (k == 3) ? 32'h02020101 : (k == 4) ? 32'hFFFFFFFF : init_w(k);
            set_port(0, 1'b1, 1'b0, 4'h0, 16'(16 + k), 32'h0);
            pulse("scan");
            cmp($sformatf("scan %h", 16 + k), snap[LAT][0][0], mk(1'b1, 1'b0, word));
        end

        // Write-first instance returns the merged word on a write
        set_port(0, 1'b1, 1'b1, 4'hF, 16'h15, 32'h12345678);
        pulse("wfirst");
        cmp("wfirst rdw1 A", snap[LAT][1][0], mk(1'b1, 1'b0, 32'h12345678));
        a_act = snap[LAT][0][0];
        cmp("wfirst rdw0 A rvalid", mk(a_act.rv, a_act.er, 32'h0), mk(1'b0, 1'b0, 32'h0));

        // Reset asserted mid-cycle while a read response is on the outputs
        set_port(0, 1'b1, 1'b0, 4'h0, 16'h15, 32'h0);
        tick("pre_rst");
        tick("pre_rst");
        cmp("pre_rst rdw0 A", act_of(0, 0), mk(1'b1, 1'b0, 32'h12345678));
        n_rst = 1'b0;
        #1;
        model_reset();
        cmp("rst drop rdw0 A", act_of(0, 0), mk(1'b0, 1'b0, 32'h0));
        cmp("rst drop rdw1 A", act_of(1, 0), mk(1'b0, 1'b0, 32'h0));
        set_port(1, 1'b1, 1'b1, 4'hF, 16'h15, 32'hBAD0BAD0);
        tick("in_rst");
        tick("in_rst");
        idle();
        n_rst = 1'b1;
        set_port(0, 1'b1, 1'b0, 4'h0, 16'h15, 32'h0);
        pulse("post_rst");
        cmp("post_rst contents", snap[LAT][0][0], mk(1'b1, 1'b0, 32'h12345678));

        // Random traffic around the window edges
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                ra = 16'($urandom_range(12, 35));
                set_port(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                         4'($urandom), ra, $urandom);
            end
            if (en[0] && en[1] && wr[0] && wr[1] && addr[0] == addr[1]) wr[1] = 1'b0;
            tick("rnd");
        end
        idle();
        tick("drain");
        tick("drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
